// File: rtl/down_timer.sv
`default_nettype none
// ============================================================================
//  Module      : down_timer
//  Description : Programmable down-counting interval timer with prescaler,
//                one-shot / auto-reload modes, terminal-count pulse and a
//                sticky done level for one-shot expiry.
//  Revision    : 1.0 - initial release
// ============================================================================
module down_timer #(
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             reload_en,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             tc,
    output logic             done
);

    // Prescaler needs at least one bit even when every cycle is a tick.
    localparam int c_PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [c_PW-1:0] c_PRE_LAST = c_PW'(PRESCALE - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [c_PW-1:0]  r_pre;
    logic [WIDTH-1:0] r_reload;

    logic w_tick;
    logic w_load_ok;
    logic w_terminal;

    // Tick and load qualifiers; a zero load value is never accepted.
    assign w_tick     = (r_pre == c_PRE_LAST);
    assign w_load_ok  = start && (load_val != '0);
    assign w_terminal = (count == WIDTH'(1));

    // Timer FSM: abort outranks start, start outranks the counting tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_pre    <= '0;
            r_reload <= '0;
            count    <= '0;
            busy     <= 1'b0;
            tc       <= 1'b0;
            done     <= 1'b0;
        end else if (abort) begin
            // Cancels everything, including a tc that would fire this edge.
            r_state <= ST_IDLE;
            r_pre   <= '0;
            count   <= '0;
            busy    <= 1'b0;
            tc      <= 1'b0;
            done    <= 1'b0;
        end else begin
            tc <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_load_ok) begin
                        count    <= load_val;
                        r_reload <= load_val;
                        r_pre    <= '0;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        r_state  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // start and load_val are deliberately ignored while running.
                    r_pre <= w_tick ? '0 : r_pre + 1'b1;
                    if (w_tick) begin
                        if (!w_terminal) begin
                            count <= count - 1'b1;
                        end else begin
                            tc <= 1'b1;
                            if (reload_en) begin
                                count <= r_reload;
                            end else begin
                                count   <= '0;
                                busy    <= 1'b0;
                                done    <= 1'b1;
                                r_state <= ST_DONE;
                            end
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_down_timer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_down_timer
//  Description : Directed self-checking bench for down_timer, using one
//                instance with PRESCALE=1 and one with PRESCALE=4 that share
//                the same stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_down_timer;

    logic       clk;
    logic       rst;
    logic       start;
    logic       abort;
    logic       reload_en;
    logic [7:0] load_val;

    logic [7:0] count_a, count_b;
    logic       busy_a, busy_b;
    logic       tc_a, tc_b;
    logic       done_a, done_b;

    int errors;
    int checks;

    down_timer #(.WIDTH(8), .PRESCALE(1)) u_p1 (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .reload_en (reload_en),
        .load_val  (load_val),
        .count     (count_a),
        .busy      (busy_a),
        .tc        (tc_a),
        .done      (done_a)
    );

    down_timer #(.WIDTH(8), .PRESCALE(4)) u_p4 (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .reload_en (reload_en),
        .load_val  (load_val),
        .count     (count_b),
        .busy      (busy_b),
        .tc        (tc_b),
        .done      (done_b)
    );

    // 10 ns clock; rising edges at 5, 15, 25 ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_idle_a(input string tag);
        chk({tag, "_a_count"}, 32'(count_a), 32'd0);
        chk({tag, "_a_busy"},  32'(busy_a),  32'd0);
        chk({tag, "_a_tc"},    32'(tc_a),    32'd0);
        chk({tag, "_a_done"},  32'(done_a),  32'd0);
    endtask

    task automatic chk_idle_b(input string tag);
        chk({tag, "_b_count"}, 32'(count_b), 32'd0);
        chk({tag, "_b_busy"},  32'(busy_b),  32'd0);
        chk({tag, "_b_tc"},    32'(tc_b),    32'd0);
        chk({tag, "_b_done"},  32'(done_b),  32'd0);
    endtask

    // One-cycle abort, then both instances must be idle.
    task automatic do_abort(input string tag);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk_idle_a(tag);
        chk_idle_b(tag);
    endtask

    // One-cycle start pulse; returns on the falling edge after the load edge.
    task automatic do_start(input logic [7:0] val, input logic rl);
        start     = 1'b1;
        load_val  = val;
        reload_en = rl;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        rst       = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        reload_en = 1'b0;
        load_val  = 8'h00;

        // Reset state
        repeat (2) @(negedge clk);
        chk_idle_a("reset");
        chk_idle_b("reset");
        rst = 1'b0;
        @(negedge clk);

        // One-shot, PRESCALE=1, N=5
        do_start(8'd5, 1'b0);
        chk("os_load_count", 32'(count_a), 32'd5);
        chk("os_load_busy",  32'(busy_a),  32'd1);
        chk("os_load_tc",    32'(tc_a),    32'd0);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            chk($sformatf("os_count_%0d", i), 32'(count_a), 32'(5 - i));
            chk($sformatf("os_tc_%0d", i),    32'(tc_a),    32'd0);
        end
        @(negedge clk);
        chk("os_term_count", 32'(count_a), 32'd0);
        chk("os_term_tc",    32'(tc_a),    32'd1);
        chk("os_term_done",  32'(done_a),  32'd1);
        chk("os_term_busy",  32'(busy_a),  32'd0);
        @(negedge clk);
        chk("os_after_tc",    32'(tc_a),    32'd0);
        chk("os_after_done",  32'(done_a),  32'd1);
        chk("os_after_count", 32'(count_a), 32'd0);
        do_abort("abort1");

        // Rejected start with zero load value
        do_start(8'd0, 1'b0);
        chk_idle_a("zero_start");
        chk_idle_b("zero_start");

        // Auto-reload, PRESCALE=4, N=3; also a start in RUN that must be ignored
        do_start(8'd3, 1'b1);
        for (int k = 0; k <= 25; k++) begin
            if (k > 0) @(negedge clk);
            chk($sformatf("rl_count_k%0d", k), 32'(count_b), 32'(3 - ((k % 12) / 4)));
            chk($sformatf("rl_tc_k%0d", k),    32'(tc_b),    32'((k > 0) && (k % 12 == 0)));
            chk($sformatf("rl_busy_k%0d", k),  32'(busy_b),  32'd1);
            chk($sformatf("rl_done_k%0d", k),  32'(done_b),  32'd0);
            if (k == 5) begin
                start    = 1'b1;
                load_val = 8'd7;
            end else begin
                start = 1'b0;
            end
        end
        do_abort("abort2");

        // Abort coinciding with the terminal tick suppresses tc
        do_start(8'd2, 1'b0);
        chk("ab_count2", 32'(count_a), 32'd2);
        @(negedge clk);
        chk("ab_count1", 32'(count_a), 32'd1);
        do_abort("abort_tc");

        // Restart from DONE
        do_start(8'd1, 1'b0);
        @(negedge clk);
        chk("rs_tc1",   32'(tc_a),   32'd1);
        chk("rs_done1", 32'(done_a), 32'd1);
        do_start(8'd2, 1'b0);
        chk("rs_done_clr", 32'(done_a),  32'd0);
        chk("rs_count2",   32'(count_a), 32'd2);
        chk("rs_busy",     32'(busy_a),  32'd1);
        chk("rs_tc0",      32'(tc_a),    32'd0);
        @(negedge clk);
        chk("rs_count1", 32'(count_a), 32'd1);
        chk("rs_tc_mid", 32'(tc_a),    32'd0);
        @(negedge clk);
        chk("rs_tc",    32'(tc_a),    32'd1);
        chk("rs_count", 32'(count_a), 32'd0);
        chk("rs_done",  32'(done_a),  32'd1);
        do_abort("abort3");

        // Full-scale one-shot, 0xFF, PRESCALE=1: no wrap below zero
        do_start(8'hFF, 1'b0);
        chk("ff_load", 32'(count_a), 32'hFF);
        for (int k = 1; k <= 254; k++) begin
            @(negedge clk);
            if (k % 50 == 0 || k == 254) begin
                chk($sformatf("ff_count_k%0d", k), 32'(count_a), 32'(255 - k));
            end
            chk($sformatf("ff_tc_k%0d", k), 32'(tc_a), 32'd0);
        end
        @(negedge clk);
        chk("ff_term_tc",    32'(tc_a),    32'd1);
        chk("ff_term_count", 32'(count_a), 32'd0);
        chk("ff_term_done",  32'(done_a),  32'd1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("ff_hold_count_%0d", k), 32'(count_a), 32'd0);
            chk($sformatf("ff_hold_tc_%0d", k),    32'(tc_a),    32'd0);
        end
        do_abort("abort4");

        // Asynchronous reset mid-RUN with count=0x37
        do_start(8'h37, 1'b0);
        chk("ar_pre_count", 32'(count_b), 32'h37);
        chk("ar_pre_busy",  32'(busy_b),  32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk_idle_b("async_rst");
        chk_idle_a("async_rst");
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk_idle_b("post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/down_timer.md
Name: down_timer

Overview:
- Programmable down-counting interval timer; the counterpart of the free-running 8-bit up counter.
- Loads a start value, decrements once per prescaled tick and flags terminal count.
- Supports one-shot and auto-reload modes.
- Drives timeouts, delays and periodic strobes for surrounding control logic.

Parameters:
WIDTH, 8, bit width of load value and count.
PRESCALE, 1, clk cycles per decrement tick (legal range >= 1). The prescaler counter width is derived from PRESCALE.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous reset, active-high
start  input  1  single-cycle request to load load_val and begin counting
abort  input  1  cancel any activity and return to idle
reload_en  input  1  1 = auto-reload at terminal count, 0 = one-shot
load_val  input  WIDTH  start value, sampled only on an accepted start
count  output  WIDTH  current remaining count
busy  output  1  high while in RUN
tc  output  1  one-cycle terminal-count pulse
done  output  1  level, high in DONE (one-shot expiry) until start or abort

Behaviour:
- Interface: one clock `clk`; reset `rst` is asynchronous and active-high.
- Reset: asserting rst immediately forces state=IDLE, count=0, busy=0, tc=0, done=0, prescaler=0, latched reload value=0. This applies at any time, including mid-RUN.
- States: IDLE, RUN, DONE.
- Priority within a cycle: rst > abort > start > tick.
- IDLE:
  - start=1 and load_val!=0: count<=load_val, latch load_val as the reload value, prescaler<=0, busy<=1, go to RUN.
  - start=1 and load_val==0: rejected; no state change, all outputs unchanged.
- RUN:
  - Prescaler increments each cycle. A tick occurs in the cycle where prescaler==PRESCALE-1; the prescaler then wraps to 0.
  - Tick with count>1: count<=count-1.
  - Tick with count==1 (terminal): tc<=1 for exactly one cycle.
    - reload_en=1 (sampled in that cycle): count<=latched reload value, stay in RUN, prescaler continues from 0.
    - reload_en=0: count<=0, busy<=0, done<=1, go to DONE.
  - start is ignored in RUN.
  - load_val changes in RUN have no effect.
- DONE:
  - count=0, done=1 held.
  - start with load_val!=0: behaves as in IDLE and also clears done in the same edge.
  - start with load_val==0: ignored.
- abort in RUN or DONE: next edge goes to IDLE; count=0, busy=0, done=0, tc=0, prescaler=0. An abort coinciding with a terminal tick suppresses tc.
- abort in IDLE: no effect.
- Timing:
  - count updates only on ticks and holds between them.
  - count never wraps below 0.
  - With start accepted at edge E0 and value N, tc is high during the cycle following edge E0+N*PRESCALE.
  - In reload mode, tc pulses every N*PRESCALE cycles.
- All outputs are registered. tc is never high for more than one consecutive cycle when PRESCALE>1.
- With PRESCALE=1 and N=1 in reload mode, tc stays high continuously. This is legal.

Test Plan:
1. Reset: assert rst mid-cycle with count=0x37 in RUN -> count=0, busy=0, tc=0, done=0 immediately, before the next clk edge.
2. One-shot, PRESCALE=1: start with load_val=5, reload_en=0 -> count 5,4,3,2,1 on successive edges; tc=1 for one cycle 5 cycles after start as count becomes 0; done=1 and busy=0 hold afterwards.
3. Auto-reload, PRESCALE=4: load_val=3, reload_en=1 -> count steps every 4 cycles 3,2,1,3,2,1,...; tc pulses every 12 cycles; busy stays 1; done stays 0.
4. Boundaries:
   - start with load_val=0 in IDLE -> no state change.
   - load_val=0xFF one-shot, PRESCALE=1 -> tc exactly 255 cycles after start, count stops at 0 and does not wrap.
5. Abort/start interaction:
   - abort asserted in the same cycle as the terminal tick -> no tc pulse, IDLE, count=0.
   - start asserted in RUN -> ignored, count sequence unperturbed.
6. Restart from DONE: after a one-shot expiry, start with load_val=2 -> done cleared on the same edge, count=2, busy=1, tc 2 cycles later (PRESCALE=1).
